// File: rtl/regbank_write_ctrl.sv
// Write-back front end and RAW hazard scoreboard for a 32 x 64-bit register bank (register 31 reads zero).
// Optional macro REGBANK_BYPASS_EN forwards the pending write-back value to the read ports a cycle early.
module regbank_write_ctrl #(
   parameter int NREG = 32,
   parameter int W    = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wb_valid,
   output logic                     o_wb_ready,
   input  logic [4:0]               i_wb_rd,
   input  logic [W-1:0]             i_wb_data,
   input  logic                     i_hold,
   input  logic                     i_iss_valid,
   input  logic [4:0]               i_iss_rd,
   input  logic [4:0]               i_rs1,
   input  logic [4:0]               i_rs2,
   input  logic [NREG-1:0][W-1:0]   i_bank_q,
   output logic [NREG-1:0][W-1:0]   o_bank_d,
   output logic [NREG-1:0]          o_bank_we,
   output logic [W-1:0]             o_rd1_data,
   output logic [W-1:0]             o_rd2_data,
   output logic                     o_rs1_busy,
   output logic                     o_rs2_busy,
   output logic [31:0]              o_commit_cnt
);

   localparam logic [4:0] ZREG = 5'(NREG - 1);

   logic              r_pend_v;
   logic [4:0]        r_pend_rd;
   logic [W-1:0]      r_pend_data;
   logic [NREG-2:0]   r_busy;
   logic [31:0]       r_commit_cnt;

   logic              w_wb_fire;
   logic              w_retire;
   logic              w_commit;
   logic [NREG-2:0]   w_busy_nxt;
   logic [4:0]        w_rs       [2];
   logic [W-1:0]      w_rd_data  [2];
   logic              w_rs_busy  [2];
   logic              w_sb_busy  [2];
   logic              w_pend_hit [2];

   // The slot may be refilled in the same cycle its current entry retires.
   assign o_wb_ready   = !r_pend_v || !i_hold;
   assign w_wb_fire    = i_wb_valid && o_wb_ready;
   assign w_retire     = r_pend_v && !i_hold;
   assign w_commit     = w_retire && (r_pend_rd != ZREG);
   assign o_commit_cnt = r_commit_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_v    <= 1'b0;
         r_pend_rd   <= '0;
         r_pend_data <= '0;
      end else if (w_wb_fire) begin
         r_pend_v    <= 1'b1;
         r_pend_rd   <= i_wb_rd;
         r_pend_data <= i_wb_data;
      end else if (w_retire) begin
         r_pend_v    <= 1'b0;
      end
   end

   // Set is applied after clear so a same-cycle issue to the same register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < NREG - 1; i++) begin
         if (w_wb_fire && (i_wb_rd == 5'(i))) begin
            w_busy_nxt[i] = 1'b0;
         end
         if (i_iss_valid && (i_iss_rd == 5'(i))) begin
            w_busy_nxt[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy       <= '0;
         r_commit_cnt <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_commit) begin
            r_commit_cnt <= r_commit_cnt + 32'd1;
         end
      end
   end

   always_comb begin
      o_bank_we = '0;
      o_bank_d  = '0;
      for (int i = 0; i < NREG; i++) begin
         o_bank_we[i] = w_commit && (r_pend_rd == 5'(i));
         o_bank_d[i]  = r_pend_data;
      end
   end

   assign w_rs[0] = i_rs1;
   assign w_rs[1] = i_rs2;

   always_comb begin
      w_sb_busy[0]  = 1'b0;
      w_sb_busy[1]  = 1'b0;
      w_pend_hit[0] = 1'b0;
      w_pend_hit[1] = 1'b0;
      w_rd_data[0]  = '0;
      w_rd_data[1]  = '0;
      w_rs_busy[0]  = 1'b0;
      w_rs_busy[1]  = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NREG - 1; i++) begin
            if (w_rs[p] == 5'(i)) begin
               w_sb_busy[p] = r_busy[i];
            end
         end
         w_pend_hit[p] = r_pend_v && (r_pend_rd == w_rs[p]) && (w_rs[p] != ZREG);
`ifdef REGBANK_BYPASS_EN
         w_rd_data[p] = w_pend_hit[p] ? r_pend_data : i_bank_q[w_rs[p]];
         w_rs_busy[p] = w_sb_busy[p];
`else
         w_rd_data[p] = i_bank_q[w_rs[p]];
         w_rs_busy[p] = w_sb_busy[p] || w_pend_hit[p];
`endif
         if (w_rs[p] == ZREG) begin
            w_rd_data[p] = '0;
            w_rs_busy[p] = 1'b0;
         end
      end
   end

   assign o_rd1_data = w_rd_data[0];
   assign o_rd2_data = w_rd_data[1];
   assign o_rs1_busy = w_rs_busy[0];
   assign o_rs2_busy = w_rs_busy[1];

endmodule
